// File: rtl/poly_sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module      : poly_sweep_pkg
// Description : Shared widths, FSM state encoding and DATA_W extremes for the
//               polynomial-evaluator sweep controller.
// Revision    : 1.0 - initial release
// ============================================================================
package poly_sweep_pkg;

    // Default widths of the evaluator interface and accumulator
    localparam int C_IN_W    = 4;
    localparam int C_DATA_W  = 19;
    localparam int C_SUM_W   = 32;
    localparam int C_TIMEOUT = 255;

    // Most-positive / most-negative values of a default-width result
    localparam logic signed [C_DATA_W-1:0] C_DATA_MAX = {1'b0, {(C_DATA_W-1){1'b1}}};
    localparam logic signed [C_DATA_W-1:0] C_DATA_MIN = {1'b1, {(C_DATA_W-1){1'b0}}};

    // Sweep FSM state encoding
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_SETUP   = 3'd1;
    localparam state_t ST_REQ     = 3'd2;
    localparam state_t ST_CAPTURE = 3'd3;
    localparam state_t ST_RELEASE = 3'd4;
    localparam state_t ST_FINISH  = 3'd5;
    localparam state_t ST_ERROR   = 3'd6;

endpackage
`default_nettype wire

// File: rtl/poly_sweep_ctrl_stats.sv
`default_nettype none
// ============================================================================
// Module      : sweep_stats
// Description : Registered running max/min (with the index of the first
//               occurrence), wrap-around sum and sample count.
// Revision    : 1.0 - initial release
// ============================================================================
module sweep_stats
    import poly_sweep_pkg::*;
#(
    parameter int DATA_W = C_DATA_W,
    parameter int SUM_W  = C_SUM_W,
    parameter int IDX_W  = 3 * C_IN_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     valid,
    input  logic signed [DATA_W-1:0] data,
    input  logic        [IDX_W-1:0]  idx,
    output logic signed [DATA_W-1:0] max_val,
    output logic signed [DATA_W-1:0] min_val,
    output logic        [IDX_W-1:0]  max_idx,
    output logic        [IDX_W-1:0]  min_idx,
    output logic signed [SUM_W-1:0]  sum,
    output logic        [IDX_W:0]    count
);

    localparam logic signed [DATA_W-1:0] C_POS = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] C_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [SUM_W-1:0] w_data_ext;

    // Sign-extend the result into the accumulator width
    always_comb begin
        w_data_ext = {{(SUM_W-DATA_W){data[DATA_W-1]}}, data};
    end

    // Clear to the identity values, otherwise fold in each valid sample;
    // strict compares keep the earliest index on ties
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_val <= C_NEG;
            min_val <= C_POS;
            max_idx <= '0;
            min_idx <= '0;
            sum     <= '0;
            count   <= '0;
        end else if (clear) begin
            max_val <= C_NEG;
            min_val <= C_POS;
            max_idx <= '0;
            min_idx <= '0;
            sum     <= '0;
            count   <= '0;
        end else if (valid) begin
            if (data > max_val) begin
                max_val <= data;
                max_idx <= idx;
            end
            if (data < min_val) begin
                min_val <= data;
                min_idx <= idx;
            end
            sum   <= sum + w_data_ext;
            count <= count + (IDX_W+1)'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/poly_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : poly_sweep_ctrl
// Description : Drives every operand combination through the polynomial
//               evaluator via its en/done handshake and reduces the results
//               to running statistics. Sticky err on evaluator timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module poly_sweep_ctrl
    import poly_sweep_pkg::*;
#(
    parameter int IN_W    = C_IN_W,
    parameter int DATA_W  = C_DATA_W,
    parameter int SUM_W   = C_SUM_W,
    parameter int TIMEOUT = C_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic                       sweep_done,
    output logic                       err,
    output logic                       ev_en,
    output logic        [IN_W-1:0]     ev_in0,
    output logic        [IN_W-1:0]     ev_in1,
    output logic        [IN_W-1:0]     ev_in2,
    input  logic                       ev_done,
    input  logic signed [DATA_W-1:0]   ev_out,
    output logic signed [DATA_W-1:0]   max_val,
    output logic signed [DATA_W-1:0]   min_val,
    output logic        [3*IN_W-1:0]   max_idx,
    output logic        [3*IN_W-1:0]   min_idx,
    output logic signed [SUM_W-1:0]    sum,
    output logic        [3*IN_W:0]     count
);

    localparam int IDX_W = 3 * IN_W;
    localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    // Value of the wait counter in the last REQ cycle before timing out
    localparam logic [TO_W-1:0]  C_TO_LAST  = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [IDX_W-1:0] C_IDX_LAST = '1;

    state_t                    r_state;
    logic        [IDX_W-1:0]   r_idx;
    logic        [TO_W-1:0]    r_wait;
    logic signed [DATA_W-1:0]  r_cap;
    logic                      r_err;
    logic                      r_arm;

    logic                      w_accept;
    logic                      w_timeout;
    logic                      w_capture;

    // Start is accepted only in IDLE and only once start has been seen low
    // since the previous sweep, so a held or late start never re-triggers
    always_comb begin
        w_accept  = (r_state == ST_IDLE) && start && r_arm;
        w_timeout = (TIMEOUT != 0) && (r_wait == C_TO_LAST);
        w_capture = (r_state == ST_CAPTURE);
    end

    // Sweep FSM, point index, timeout counter and result capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_wait  <= '0;
            r_cap   <= '0;
            r_err   <= 1'b0;
            r_arm   <= 1'b1;
        end else begin
            if (w_accept) begin
                r_arm <= 1'b0;
            end else if ((r_state != ST_IDLE) && start) begin
                r_arm <= 1'b0;
            end else if (!start) begin
                r_arm <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_SETUP;
                        r_idx   <= '0;
                        r_err   <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    r_wait  <= '0;
                    r_state <= ST_REQ;
                end
                ST_REQ: begin
                    if (ev_done) begin
                        r_cap   <= ev_out;
                        r_state <= ST_CAPTURE;
                    end else if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= ST_ERROR;
                    end else begin
                        r_wait  <= r_wait + TO_W'(1);
                    end
                end
                ST_CAPTURE: begin
                    r_state <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    if (!ev_done) begin
                        if (r_idx == C_IDX_LAST) begin
                            r_state <= ST_FINISH;
                        end else begin
                            r_idx   <= r_idx + IDX_W'(1);
                            r_state <= ST_SETUP;
                        end
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                end
                ST_ERROR: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Decoded outputs; ev_en follows the state register so reset drops it at once
    always_comb begin
        busy       = (r_state != ST_IDLE);
        sweep_done = (r_state == ST_FINISH) || (r_state == ST_ERROR);
        err        = r_err;
        ev_en      = (r_state == ST_REQ);
        ev_in0     = r_idx[3*IN_W-1:2*IN_W];
        ev_in1     = r_idx[2*IN_W-1:IN_W];
        ev_in2     = r_idx[IN_W-1:0];
    end

    sweep_stats #(
        .DATA_W (DATA_W),
        .SUM_W  (SUM_W),
        .IDX_W  (IDX_W)
    ) u_stats (
        .clk     (clk),
        .rst     (rst),
        .clear   (w_accept),
        .valid   (w_capture),
        .data    (r_cap),
        .idx     (r_idx),
        .max_val (max_val),
        .min_val (min_val),
        .max_idx (max_idx),
        .min_idx (min_idx),
        .sum     (sum),
        .count   (count)
    );

endmodule
`default_nettype wire

// File: tb/tb_poly_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_poly_sweep_ctrl
// Description : Directed bench for poly_sweep_ctrl with a behavioural
//               evaluator (F = 5x^2+8x-4y^2+3y+6z^2-2z+13, random latency).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_poly_sweep_ctrl;

    localparam int IN_W   = 4;
    localparam int DATA_W = 19;
    localparam int SUM_W  = 32;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       start;
    logic                       busy;
    logic                       sweep_done;
    logic                       err;
    logic                       ev_en;
    logic        [IN_W-1:0]     ev_in0;
    logic        [IN_W-1:0]     ev_in1;
    logic        [IN_W-1:0]     ev_in2;
    logic                       ev_done;
    logic signed [DATA_W-1:0]   ev_out;
    logic signed [DATA_W-1:0]   max_val;
    logic signed [DATA_W-1:0]   min_val;
    logic        [3*IN_W-1:0]   max_idx;
    logic        [3*IN_W-1:0]   min_idx;
    logic signed [SUM_W-1:0]    sum;
    logic        [3*IN_W:0]     count;

    poly_sweep_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .sweep_done (sweep_done),
        .err        (err),
        .ev_en      (ev_en),
        .ev_in0     (ev_in0),
        .ev_in1     (ev_in1),
        .ev_in2     (ev_in2),
        .ev_done    (ev_done),
        .ev_out     (ev_out),
        .max_val    (max_val),
        .min_val    (min_val),
        .max_idx    (max_idx),
        .min_idx    (min_idx),
        .sum        (sum),
        .count      (count)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_value(input string tag, input logic signed [63:0] obs,
                               input logic signed [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Evaluator model: mode 0 = polynomial, 1 = polynomial but never done at
    // point 5, 2 = constant 13
    int mode    = 0;
    int lat_max = 6;
    int wcnt    = 0;
    int lat     = 1;

    function automatic int f_model(input int x, input int y, input int z);
        return 5*x*x + 8*x - 4*y*y + 3*y + 6*z*z - 2*z + 13;
    endfunction

    initial begin
        ev_done = 1'b0;
        ev_out  = '0;
        forever begin
            @(negedge clk);
            if (!ev_en) begin
                ev_done = 1'b0;
                wcnt    = 0;
            end else if (!ev_done) begin
                wcnt++;
                if (wcnt == 1) lat = $urandom_range(1, lat_max);
                if (wcnt >= lat && !(mode == 1 && {ev_in0, ev_in1, ev_in2} == 12'd5)) begin
                    ev_done = 1'b1;
                    if (mode == 2) ev_out = DATA_W'(13);
                    else ev_out = DATA_W'(f_model(int'(ev_in0), int'(ev_in1), int'(ev_in2)));
                end
            end
        end
    end

    // Handshake monitor: operand stability under ev_en, no new request while
    // done is still high, sweep_done pulse count and length of each request
    int          hs_err       = 0;
    int          done_pulses  = 0;
    int          req_run      = 0;
    int          last_req_run = 0;
    logic        prev_en      = 1'b0;
    logic [11:0] prev_ops     = '0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (prev_en && ev_en && ({ev_in0, ev_in1, ev_in2} != prev_ops)) hs_err++;
            if (!prev_en && ev_en && ev_done) hs_err++;
            if (sweep_done) done_pulses++;
            if (ev_en) begin
                req_run++;
            end else if (prev_en) begin
                last_req_run = req_run;
                req_run      = 0;
            end
            prev_en  = ev_en;
            prev_ops = {ev_in0, ev_in1, ev_in2};
        end
    end

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_sweep_done(input int budget, input string tag);
        int n = 0;
        while (!sweep_done && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_value({tag, "_done_seen"}, sweep_done, 1);
    endtask

    task automatic check_full(input string tag);
        check_value({tag, "_max_val"}, max_val, 2578);
        check_value({tag, "_max_idx"}, max_idx, 12'hF0F);
        check_value({tag, "_min_val"}, min_val, -842);
        check_value({tag, "_min_idx"}, min_idx, 12'h0F0);
        check_value({tag, "_sum"},     sum,     2551808);
        check_value({tag, "_count"},   count,   4096);
        check_value({tag, "_err"},     err,     0);
    endtask

    int busy_seen;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_busy",    busy,       0);
        check_value("rst_done",    sweep_done, 0);
        check_value("rst_err",     err,        0);
        check_value("rst_ev_en",   ev_en,      0);
        check_value("rst_ops",     {ev_in0, ev_in1, ev_in2}, 0);
        check_value("rst_max_val", max_val,    -262144);
        check_value("rst_min_val", min_val,    262143);
        check_value("rst_sum",     sum,        0);
        check_value("rst_count",   count,      0);
        @(negedge clk);
        rst = 1'b0;

        // Full sweep, random latency, start held high throughout
        done_pulses = 0;
        hs_err      = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check_value("a_busy_after_start", busy, 1);
        wait_sweep_done(60000, "a");
        check_full("a");
        busy_seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (busy) busy_seen = 1;
        end
        check_value("a_held_start_no_resweep", busy_seen, 0);
        check_value("a_done_pulses", done_pulses, 1);
        check_value("a_handshake", hs_err, 0);

        // Reassert start in IDLE with an evaluator that hangs at point 5
        @(negedge clk);
        start = 1'b0;
        mode  = 1;
        start_pulse();
        @(posedge clk);
        #1;
        check_value("to_busy_after_restart", busy, 1);
        wait_sweep_done(5000, "to");
        check_value("to_err",      err,     1);
        check_value("to_count",    count,   5);
        check_value("to_sum",      sum,     225);
        check_value("to_max_val",  max_val, 101);
        check_value("to_max_idx",  max_idx, 4);
        check_value("to_min_val",  min_val, 13);
        check_value("to_min_idx",  min_idx, 0);
        @(posedge clk);
        #1;
        check_value("to_req_cycles", last_req_run, 255);
        check_value("to_idle",       busy,         0);
        check_value("to_err_sticky", err,          1);

        // Restart clears err; reset at point 1000
        mode    = 0;
        lat_max = 1;
        start_pulse();
        @(posedge clk);
        #1;
        check_value("rs_err_cleared", err, 0);
        begin
            int n = 0;
            while (!(ev_en && {ev_in0, ev_in1, ev_in2} == 12'd1000) && n < 20000) begin
                @(posedge clk);
                #1;
                n++;
            end
            check_value("rs_reached_1000", {ev_in0, ev_in1, ev_in2}, 1000);
        end
        rst = 1'b1;
        #1;
        check_value("rs_ev_en",    ev_en,   0);
        check_value("rs_busy",     busy,    0);
        check_value("rs_ops",      {ev_in0, ev_in1, ev_in2}, 0);
        check_value("rs_count",    count,   0);
        check_value("rs_sum",      sum,     0);
        check_value("rs_max_val",  max_val, -262144);
        check_value("rs_min_val",  min_val, 262143);
        check_value("rs_max_idx",  max_idx, 0);
        check_value("rs_min_idx",  min_idx, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Full sweep after reset
        done_pulses = 0;
        hs_err      = 0;
        start_pulse();
        wait_sweep_done(40000, "b");
        check_full("b");
        @(posedge clk);
        #1;
        check_value("b_done_pulses", done_pulses, 1);
        check_value("b_handshake",   hs_err,      0);

        // Constant results: ties keep index 0
        mode    = 2;
        lat_max = 2;
        start_pulse();
        wait_sweep_done(40000, "c");
        check_value("c_max_val", max_val, 13);
        check_value("c_min_val", min_val, 13);
        check_value("c_max_idx", max_idx, 0);
        check_value("c_min_idx", min_idx, 0);
        check_value("c_sum",     sum,     53248);
        check_value("c_count",   count,   4096);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
